// File: rtl/ad9231_pkg.sv
// Shared definitions for the AD9231 capture path: capture FSM encoding,
// default sample width and the {chb, cha} sample-word layout.
package ad9231_pkg;

  localparam int DAT_W_DEF = 12;

  // Slot index of each channel inside a packed sample word (cha in the low half).
  localparam int CHA_SLOT = 0;
  localparam int CHB_SLOT = 1;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_PRETRIG   = 5'b00010,
    ST_WAIT_TRIG = 5'b00100,
    ST_POSTTRIG  = 5'b01000,
    ST_DONE      = 5'b10000
  } cap_state_e;

endpackage

// File: rtl/ad9231_capture_ram.sv
// Simple dual-port sample RAM, one clock, registered read.
// A read of the word being written in the same cycle returns the old contents.
module ad9231_capture_ram #(
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ad9231_capture_buffer.sv
// Circular dual-channel capture buffer with level-crossing / forced trigger,
// pre/post-trigger window freeze and a 1-cycle random-access readout port.
module ad9231_capture_buffer
  import ad9231_pkg::*;
#(
  parameter int DAT_W  = DAT_W_DEF,
  parameter int ADDR_W = 10
) (
  input  logic                clk_200m,
  input  logic                rst_n,
  input  logic [DAT_W-1:0]    cha_dat,
  input  logic [DAT_W-1:0]    chb_dat,
  input  logic                dat_valid,
  input  logic                arm,
  input  logic                force_trig,
  input  logic                trig_ch,
  input  logic [DAT_W-1:0]    trig_level,
  input  logic [ADDR_W-1:0]   pre_len,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [2*DAT_W-1:0]  rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                capture_done,
  output logic [ADDR_W-1:0]   start_addr
);

  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  cap_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W:0]   post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic              trig_ch_q, trig_ch_d;
  logic [DAT_W-1:0]  trig_level_q, trig_level_d;
  logic [ADDR_W-1:0] pre_len_q, pre_len_d;
  logic [DAT_W-1:0]  prev_sel_q, prev_sel_d;
  logic              prev_valid_q, prev_valid_d;
  logic              force_pend_q, force_pend_d;
  logic              rd_valid_q;

  logic              wr_en;
  logic [2*DAT_W-1:0] wr_word;
  logic [2*DAT_W-1:0] ram_dout;
  logic [DAT_W-1:0]  cur_sel;
  logic [ADDR_W:0]   post_len;
  logic [ADDR_W-1:0] rd_phys;
  logic              level_hit;
  logic              busy_w;

  always_comb begin
    wr_word = '0;
    wr_word[CHA_SLOT*DAT_W +: DAT_W] = cha_dat;
    wr_word[CHB_SLOT*DAT_W +: DAT_W] = chb_dat;
  end

  assign cur_sel   = trig_ch_q ? chb_dat : cha_dat;
  assign post_len  = DEPTH_C - {1'b0, pre_len_q};
  assign level_hit = prev_valid_q && (prev_sel_q < trig_level_q) && (cur_sel >= trig_level_q);
  assign busy_w    = (state_q == ST_PRETRIG) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POSTTRIG);
  assign rd_phys   = start_addr_q + rd_addr;

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    start_addr_d = start_addr_q;
    trig_ch_d    = trig_ch_q;
    trig_level_d = trig_level_q;
    pre_len_d    = pre_len_q;
    prev_sel_d   = prev_sel_q;
    prev_valid_d = prev_valid_q;
    force_pend_d = 1'b0;
    wr_en        = 1'b0;

    if (busy_w && dat_valid) begin
      prev_sel_d   = cur_sel;
      prev_valid_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: ;
      ST_PRETRIG: begin
        if (dat_valid) begin
          wr_en     = 1'b1;
          wptr_d    = wptr_q + 1'b1;
          pre_cnt_d = pre_cnt_q + 1'b1;
        end
        if ((pre_len_q == '0) || (pre_cnt_d == pre_len_q)) state_d = ST_WAIT_TRIG;
      end
      ST_WAIT_TRIG: begin
        // A software trigger between samples waits for the next sample.
        force_pend_d = force_pend_q | force_trig;
        if (dat_valid) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (level_hit || force_pend_q || force_trig) begin
            start_addr_d = wptr_q - pre_len_q;
            post_cnt_d   = (ADDR_W+1)'(1);
            force_pend_d = 1'b0;
            state_d      = (post_len == (ADDR_W+1)'(1)) ? ST_DONE : ST_POSTTRIG;
          end
        end
      end
      ST_POSTTRIG: begin
        if (dat_valid) begin
          wr_en      = 1'b1;
          wptr_d     = wptr_q + 1'b1;
          post_cnt_d = post_cnt_q + 1'b1;
          if (post_cnt_d == post_len) state_d = ST_DONE;
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase

    // Arm overrides everything, including a trigger landing in the same cycle.
    if (arm) begin
      state_d      = ST_PRETRIG;
      wr_en        = 1'b0;
      wptr_d       = '0;
      pre_cnt_d    = '0;
      post_cnt_d   = '0;
      prev_valid_d = 1'b0;
      force_pend_d = 1'b0;
      trig_ch_d    = trig_ch;
      trig_level_d = trig_level;
      pre_len_d    = pre_len;
    end
  end

  always_ff @(posedge clk_200m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wptr_q       <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      start_addr_q <= '0;
      trig_ch_q    <= 1'b0;
      trig_level_q <= '0;
      pre_len_q    <= '0;
      prev_sel_q   <= '0;
      prev_valid_q <= 1'b0;
      force_pend_q <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      start_addr_q <= start_addr_d;
      trig_ch_q    <= trig_ch_d;
      trig_level_q <= trig_level_d;
      pre_len_q    <= pre_len_d;
      prev_sel_q   <= prev_sel_d;
      prev_valid_q <= prev_valid_d;
      force_pend_q <= force_pend_d;
      rd_valid_q   <= rd_en;
    end
  end

  ad9231_capture_ram #(
    .WIDTH  (2*DAT_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk_200m),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (wr_word),
    .re_i    (rd_en),
    .raddr_i (rd_phys),
    .rdata_o (ram_dout)
  );

  // RAM output register has no reset; gating with rd_valid gives zero out of reset.
  assign rd_data      = rd_valid_q ? ram_dout : '0;
  assign rd_valid     = rd_valid_q;
  assign busy         = busy_w;
  assign capture_done = (state_q == ST_DONE);
  assign start_addr   = start_addr_q;

endmodule

// File: doc/ad9231_capture_buffer.md
Name: ad9231_capture_buffer

Overview:
- Downstream consumer of read_ad_dat_from_ad9231.
- Takes its per-sample channel A/B words and one-cycle valid strobe, and stores them in a circular dual-channel sample RAM.
- Detects a level-crossing trigger on a selected channel, freezes a pre/post-trigger window, and exposes it through a random-access read port for the readout/MCU interface.
- Everything runs in the clk_200m domain.

Parameters:
- DAT_W, 12, sample width per channel (AD9231 resolution).
- ADDR_W, 10, RAM address width; DEPTH = 2**ADDR_W samples per capture.

Ports:
- clk_200m  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cha_dat  in  DAT_W  channel A sample, offset binary.
- chb_dat  in  DAT_W  channel B sample, offset binary.
- dat_valid  in  1  one-cycle strobe; cha_dat/chb_dat are valid in that cycle.
- arm  in  1  one-cycle pulse; starts or restarts a capture.
- force_trig  in  1  one-cycle pulse; software trigger.
- trig_ch  in  1  trigger source: 0 = channel A, 1 = channel B.
- trig_level  in  DAT_W  trigger threshold, unsigned.
- pre_len  in  ADDR_W  number of samples kept before the trigger sample.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address, offset from start_addr.
- rd_data  out  2*DAT_W  {chb, cha} at RAM[(start_addr + rd_addr) mod DEPTH].
- rd_valid  out  1  rd_data valid.
- busy  out  1  capture in progress.
- capture_done  out  1  window frozen; level signal.
- start_addr  out  ADDR_W  physical address of the oldest sample in the window.

Behaviour:

Reset:
- Reset is asynchronous on rst_n (active-low); clock is clk_200m.
- In reset: state = IDLE; busy, capture_done, rd_valid = 0; start_addr = 0; rd_data = 0; write pointer = 0; counters = 0; prev_valid = 0.
- trig_ch, trig_level and pre_len are sampled on arm and held for the whole capture.

States (one-hot, shared package):
- IDLE: no writes. arm -> PRETRIG.
- PRETRIG: each dat_valid writes {chb,cha} at wptr, then wptr++ and pre_cnt++. When pre_cnt reaches pre_len -> WAIT_TRIG. If pre_len = 0, go directly to WAIT_TRIG on the next cycle. Triggers are ignored in PRETRIG.
- WAIT_TRIG: keeps writing circularly; wptr wraps from DEPTH-1 to 0.
  - Trigger condition, evaluated on a dat_valid cycle: prev_valid && prev_sel < trig_level && cur_sel >= trig_level, where sel is the channel chosen by trig_ch. force_trig also triggers.
  - On trigger: the current sample is written; start_addr <= wptr - pre_len (mod DEPTH); post_cnt <= 1; next state POSTTRIG.
  - If force_trig lands in a non-valid cycle, it is latched and applied on the next dat_valid.
- POSTTRIG: keeps writing. When post_cnt reaches DEPTH - pre_len (trigger sample included) -> DONE.
- DONE: no writes; capture_done = 1 (asserted the cycle after the last write).
  - arm -> PRETRIG; capture_done clears on the same edge.

Pipeline details:
- prev_sel is updated on every dat_valid while busy. prev_valid clears on arm, so the first sample after arm can never trigger.
- busy = 1 in PRETRIG, WAIT_TRIG and POSTTRIG.

Boundary conditions:
- arm mid-capture: abort and restart from PRETRIG; wptr and counters clear, and configuration is resampled.
- arm in the same cycle as a trigger: arm wins.
- pre_len = DEPTH-1: post window is 1 sample (the trigger sample only).
- Every window contains exactly DEPTH samples.

Read port:
- Independent of capture. rd_valid and rd_data arrive 1 cycle after rd_en; read latency is fixed at 1.
- Read data is guaranteed only while capture_done = 1; otherwise reads return the current RAM contents.

RAM:
- Simple dual-port, single clock.
- A read of the address being written in the same cycle returns old data.

Decomposition:
- Package ad9231_pkg: state encodings (IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, DONE), DAT_W default, and sample-word packing order {chb, cha}.
- One sub-module, ad9231_capture_ram: parameterised simple dual-port RAM, DEPTH x 2*DAT_W, inferred block RAM, registered read.

Test Plan:
1. Reset asserted mid-POSTTRIG -> all outputs return to reset values immediately; after release, state is IDLE and no writes occur on dat_valid.
2. ADDR_W=4, pre_len=4, trig_ch=0, trig_level=0x800; cha ramps 0x7F0, 0x7F8, 0x800 ... after 10 samples -> trigger on the first 0x800 sample; capture_done after 12 more valids (16 total after trigger counting pre-samples); reading rd_addr 0..15 returns 4 pre samples, then 0x800, 0x808 ...
3. Channel A at a constant 0x900 from the first sample after arm, trig_level=0x800 -> no trigger (no rising crossing); force_trig pulse -> window captured; start_addr = wptr_at_force - pre_len mod 16.
4. pre_len=0 and pre_len=15 (ADDR_W=4) -> post lengths of 16 and 1; rd_addr 0 returns the trigger sample and the 16th-from-last sample respectively.
5. arm pulsed during WAIT_TRIG after wptr has wrapped -> busy stays 1, capture_done stays 0, pre_cnt restarts, and the capture that follows completes with correct start_addr.
6. Reads in DONE with rd_en high in consecutive cycles -> rd_valid follows rd_en delayed by 1 cycle; rd_data matches expected {chb,cha} words; dat_valid toggling in DONE leaves the RAM unchanged.
